// File: rtl/ssp_serial_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ssp_serial_port
//  Purpose  : Synchronous serial port, TI-style frame format. Host writes go
//             through a 4-deep TX FIFO and are shifted out MSB-first with a
//             one-bit frame pulse. Received serial words are assembled into
//             bytes and queued in a 4-deep RX FIFO for the host to read.
//  Ports    : pclk       - sole clock, rising edge
//             clear_b    - synchronous active-high reset
//             psel/pwrite/pwdata - host bus (write = TX push, read = RX pop)
//             prdata     - RX FIFO head (0 when empty)
//             sspclkin/sspfssin/ssprxd - receive clock, frame, data
//             ssptxd/sspclkout/sspfssout/sspoe_b - transmit side
//             ssptxintr/ssprxintr - TX FIFO full / RX FIFO full
//  Revision : 1.0 - initial release
// ============================================================================
module ssp_serial_port (
    input  logic       pclk,
    input  logic       clear_b,
    input  logic       psel,
    input  logic       pwrite,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    input  logic       sspclkin,
    input  logic       sspfssin,
    input  logic       ssprxd,
    output logic       ssptxd,
    output logic       sspclkout,
    output logic       sspfssout,
    output logic       sspoe_b,
    output logic       ssptxintr,
    output logic       ssprxintr
);

    localparam logic [2:0] c_depth    = 3'd4;
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_frame = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;

    // ------------------------------------------------------------------
    // Serial clock: free-running pclk/2. A tick is the edge where it rises.
    // ------------------------------------------------------------------
    logic r_sclk;
    logic w_tick;

    assign w_tick = ~r_sclk;

    always_ff @(posedge pclk) begin
        if (clear_b) r_sclk <= 1'b0;
        else         r_sclk <= ~r_sclk;
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0] r_tx_mem [0:3];
    logic [1:0] r_tx_wptr, r_tx_rptr;
    logic [2:0] r_tx_count;
    logic       w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [7:0] w_tx_head;

    assign w_tx_empty = (r_tx_count == 3'd0);
    assign w_tx_full  = (r_tx_count == c_depth);
    assign w_tx_head  = r_tx_mem[r_tx_rptr];
    // A write into a full FIFO still lands if the transmitter frees a slot
    // on the same edge.
    assign w_tx_push  = psel & pwrite & (~w_tx_full | w_tx_pop);

    always_ff @(posedge pclk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= pwdata;
    end

    always_ff @(posedge pclk) begin
        if (clear_b) begin
            r_tx_wptr  <= 2'd0;
            r_tx_rptr  <= 2'd0;
            r_tx_count <= 3'd0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 2'd1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 2'd1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 3'd1;
                2'b01:   r_tx_count <= r_tx_count - 3'd1;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX state machine. r_bitcnt is the index of the bit now on ssptxd.
    // ------------------------------------------------------------------
    logic [1:0] r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [2:0] r_bitcnt, w_bitcnt_nxt;
    logic       r_txd, w_txd_nxt;
    logic       r_fss, w_fss_nxt;
    logic       r_oe_b, w_oe_b_nxt;

    always_ff @(posedge pclk) begin
        if (clear_b) begin
            r_state  <= c_st_idle;
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_txd    <= 1'b0;
            r_fss    <= 1'b0;
            r_oe_b   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_txd    <= w_txd_nxt;
            r_fss    <= w_fss_nxt;
            r_oe_b   <= w_oe_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_txd_nxt    = r_txd;
        w_fss_nxt    = r_fss;
        w_oe_b_nxt   = r_oe_b;
        w_tx_pop     = 1'b0;
        if (w_tick) begin
            case (r_state)
                c_st_idle: begin
                    if (!w_tx_empty) begin
                        w_tx_pop    = 1'b1;
                        w_shift_nxt = w_tx_head;
                        w_fss_nxt   = 1'b1;
                        w_state_nxt = c_st_frame;
                    end
                end
                c_st_frame: begin
                    w_fss_nxt    = 1'b0;
                    w_oe_b_nxt   = 1'b0;
                    w_txd_nxt    = r_shift[7];
                    w_bitcnt_nxt = 3'd7;
                    w_state_nxt  = c_st_shift;
                end
                c_st_shift: begin
                    if (r_bitcnt != 3'd0) begin
                        w_bitcnt_nxt = r_bitcnt - 3'd1;
                        w_txd_nxt    = r_shift[r_bitcnt - 3'd1];
                        // Bit 0 goes out now; it is already captured in
                        // w_txd_nxt, so the shift register can take the next
                        // word and the frame pulse overlaps the bit-0 period.
                        if ((r_bitcnt == 3'd1) && !w_tx_empty) begin
                            w_tx_pop    = 1'b1;
                            w_shift_nxt = w_tx_head;
                            w_fss_nxt   = 1'b1;
                        end
                    end else if (r_fss) begin
                        w_fss_nxt    = 1'b0;
                        w_txd_nxt    = r_shift[7];
                        w_bitcnt_nxt = 3'd7;
                    end else begin
                        w_oe_b_nxt  = 1'b1;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = c_st_idle;
                    end
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX sampling and deserialiser
    // ------------------------------------------------------------------
    logic       r_clkin_s, r_clkin_d, r_fssin_s, r_rxd_s;
    logic       r_rx_active;
    logic [2:0] r_rx_cnt;
    logic [7:0] r_rx_shift;
    logic       w_fall, w_rx_last, w_rx_done;
    logic [7:0] w_rx_byte;

    assign w_fall    = r_clkin_d & ~r_clkin_s;
    assign w_rx_last = r_rx_active & (r_rx_cnt == 3'd7);
    assign w_rx_done = w_fall & w_rx_last;
    assign w_rx_byte = {r_rx_shift[6:0], r_rxd_s};

    always_ff @(posedge pclk) begin
        if (clear_b) begin
            r_clkin_s   <= 1'b0;
            r_clkin_d   <= 1'b0;
            r_fssin_s   <= 1'b0;
            r_rxd_s     <= 1'b0;
            r_rx_active <= 1'b0;
            r_rx_cnt    <= 3'd0;
            r_rx_shift  <= 8'h00;
        end else begin
            r_clkin_s <= sspclkin;
            r_clkin_d <= r_clkin_s;
            r_fssin_s <= sspfssin;
            r_rxd_s   <= ssprxd;
            if (w_fall) begin
                if (r_rx_active) begin
                    r_rx_shift <= w_rx_byte;
                    r_rx_cnt   <= r_rx_cnt + 3'd1;
                    if (r_rx_cnt == 3'd7) r_rx_active <= 1'b0;
                end
                // Frame pulse re-arms on the last bit so words can run
                // back-to-back.
                if (r_fssin_s && (!r_rx_active || w_rx_last)) begin
                    r_rx_active <= 1'b1;
                    r_rx_cnt    <= 3'd0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0] r_rx_mem [0:3];
    logic [1:0] r_rx_wptr, r_rx_rptr;
    logic [2:0] r_rx_count;
    logic       w_rx_empty, w_rx_push, w_rx_pop;

    assign w_rx_empty = (r_rx_count == 3'd0);
    assign w_rx_pop   = psel & ~pwrite & ~w_rx_empty;
    assign w_rx_push  = w_rx_done & ((r_rx_count != c_depth) | w_rx_pop);

    always_ff @(posedge pclk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= w_rx_byte;
    end

    always_ff @(posedge pclk) begin
        if (clear_b) begin
            r_rx_wptr  <= 2'd0;
            r_rx_rptr  <= 2'd0;
            r_rx_count <= 3'd0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 2'd1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 2'd1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 3'd1;
                2'b01:   r_rx_count <= r_rx_count - 3'd1;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign prdata    = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];
    assign ssptxd    = r_txd;
    assign sspclkout = r_sclk;
    assign sspfssout = r_fss;
    assign sspoe_b   = r_oe_b;
    assign ssptxintr = w_tx_full;
    assign ssprxintr = (r_rx_count == c_depth);

endmodule
`default_nettype wire

// File: tb/tb_ssp_serial_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ssp_serial_port
//  Purpose  : Self-checking bench for ssp_serial_port with the serial TX side
//             looped back to the RX side.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ssp_serial_port;

    logic       pclk = 1'b0;
    logic       clear_b = 1'b1;
    logic       psel = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] prdata;
    logic       ssptxd, sspclkout, sspfssout, sspoe_b, ssptxintr, ssprxintr;
    logic       sspclkin, sspfssin, ssprxd;

    assign sspclkin = sspclkout;
    assign sspfssin = sspfssout;
    assign ssprxd   = ssptxd;

    ssp_serial_port dut (
        .pclk      (pclk),
        .clear_b   (clear_b),
        .psel      (psel),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .sspclkin  (sspclkin),
        .sspfssin  (sspfssin),
        .ssprxd    (ssprxd),
        .ssptxd    (ssptxd),
        .sspclkout (sspclkout),
        .sspfssout (sspfssout),
        .sspoe_b   (sspoe_b),
        .ssptxintr (ssptxintr),
        .ssprxintr (ssprxintr)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int tx_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Decodes the serial line: a frame pulse seen at a serial-clock rise
    // announces a word whose 8 bits appear at the following 8 rises.
    logic       mon_prev = 1'b0;
    logic       mon_busy = 1'b0;
    int         mon_n = 0;
    logic [7:0] mon_sh = 8'h00;

    always @(negedge pclk) begin
        if (clear_b) begin
            mon_busy = 1'b0;
            mon_n    = 0;
            mon_prev = 1'b0;
        end else begin
            if (!mon_prev && sspclkout) begin
                if (mon_busy) begin
                    check("tx_oe_during_bit", sspoe_b, 0);
                    mon_sh = {mon_sh[6:0], ssptxd};
                    mon_n++;
                    if (mon_n == 8) begin
                        mon_busy = 1'b0;
                        tx_done++;
                        if (tx_exp.size() == 0) fail_now("tx_unexpected_word");
                        else check("tx_word", mon_sh, tx_exp.pop_front());
                    end
                end
                if (sspfssout) begin
                    mon_busy = 1'b1;
                    mon_n    = 0;
                end
            end
            mon_prev = sspclkout;
        end
    end

    typedef struct {
        logic       rst, sel, wr;
        logic [7:0] wd;
        logic       txi, rxi, fss, oe, sclk, txd;
    } vec_t;

    initial begin
        vec_t       tbl[10];
        logic [7:0] first4[4];
        int         base, oe_gap, fss_seen, sent;
        logic [7:0] b;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        first4 = '{8'h0F, 8'hAA, 8'hF0, 8'h55};

        // Reset, fill-and-overflow sequence, cycle by cycle.
        tx_exp = '{8'h0F, 8'hAA, 8'hF0, 8'h55, 8'h0F};
        for (int i = 0; i < 10; i++) begin
            clear_b = tbl[i].rst;
            psel    = tbl[i].sel;
            pwrite  = tbl[i].wr;
            pwdata  = tbl[i].wd;
            step();
            check($sformatf("v%0d_txintr", i), ssptxintr, tbl[i].txi);
            check($sformatf("v%0d_rxintr", i), ssprxintr, tbl[i].rxi);
            check($sformatf("v%0d_fss", i),    sspfssout, tbl[i].fss);
            check($sformatf("v%0d_oe_b", i),   sspoe_b,   tbl[i].oe);
            check($sformatf("v%0d_sclk", i),   sspclkout, tbl[i].sclk);
            check($sformatf("v%0d_txd", i),    ssptxd,    tbl[i].txd);
            check($sformatf("v%0d_prdata", i), prdata,    8'h00);
        end
        psel = 1'b0;

        // Back-to-back transmission of the four queued words.
        for (int i = 0; i < 100 && tx_done < 1; i++) step();
        check("tx_first_word_seen", tx_done, 1);
        check("txintr_clears_after_pop", ssptxintr, 0);
        oe_gap = 0;
        for (int i = 0; i < 200 && tx_done < 5; i++) begin
            if (sspoe_b !== 1'b0) oe_gap++;
            step();
        end
        check("tx_five_words_seen", tx_done, 5);
        check("oe_low_across_words", oe_gap, 0);
        for (int i = 0; i < 4; i++) step();
        check("oe_high_after_last", sspoe_b, 1);
        for (int i = 0; i < 10; i++) step();
        check("rxintr_full", ssprxintr, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rx_read%0d", k), prdata, first4[k]);
            psel = 1'b1; pwrite = 1'b0;
            step();
            psel = 1'b0;
        end
        check("rx_empty_after_reads", prdata, 8'h00);
        check("rxintr_clear", ssprxintr, 0);

        // Single-word loopback.
        tx_exp.push_back(8'hA5);
        psel = 1'b1; pwrite = 1'b1; pwdata = 8'hA5;
        step();
        psel = 1'b0; pwrite = 1'b0;
        for (int i = 0; i < 100 && tx_done < 6; i++) step();
        check("loop_tx_seen", tx_done, 6);
        for (int i = 0; i < 10; i++) step();
        check("loop_rx_head", prdata, 8'hA5);
        psel = 1'b1;
        step();
        psel = 1'b0;
        check("loop_rx_after_read", prdata, 8'h00);

        // Random traffic against the queue model; words are nonzero so that
        // prdata!=0 identifies a non-empty RX FIFO.
        base = tx_done;
        sent = 0;
        rx_exp.delete();
        begin : rand_phase
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (sent == 24 && tx_done >= base + 24 && rx_exp.size() == 0) disable rand_phase;
                if (sent < 24 && !ssptxintr && $urandom_range(0, 2) == 0) begin
                    b = 8'($urandom_range(1, 255));
                    tx_exp.push_back(b);
                    rx_exp.push_back(b);
                    sent++;
                    psel = 1'b1; pwrite = 1'b1; pwdata = b;
                end else if ($urandom_range(0, 1) == 1) begin
                    if (prdata != 8'h00) begin
                        if (rx_exp.size() == 0) fail_now("rand_rx_unexpected");
                        else check("rand_rx", prdata, rx_exp.pop_front());
                    end
                    psel = 1'b1; pwrite = 1'b0;
                end else begin
                    psel = 1'b0; pwrite = 1'b0;
                end
                step();
                psel = 1'b0; pwrite = 1'b0;
            end
            fail_now("rand_timeout");
        end
        check("rand_tx_words", tx_done - base, 24);
        check("rand_tx_queue_empty", tx_exp.size(), 0);

        // Reset in the middle of a word.
        tx_exp.push_back(8'h3C);
        for (int k = 0; k < 3; k++) begin
            psel = 1'b1; pwrite = 1'b1;
            pwdata = (k == 0) ? 8'h3C : ((k == 1) ? 8'hC3 : 8'h81);
            step();
        end
        psel = 1'b0; pwrite = 1'b0;
        for (int i = 0; i < 100 && prdata == 8'h00; i++) step();
        check("rst_pre_rx", prdata, 8'h3C);
        for (int i = 0; i < 4; i++) step();
        check("rst_pre_oe", sspoe_b, 0);
        clear_b = 1'b1;
        step();
        check("rst_oe_b", sspoe_b, 1);
        check("rst_txintr", ssptxintr, 0);
        check("rst_rxintr", ssprxintr, 0);
        check("rst_prdata", prdata, 8'h00);
        check("rst_fss", sspfssout, 0);
        check("rst_sclk", sspclkout, 0);
        check("rst_txd", ssptxd, 0);
        clear_b = 1'b0;
        tx_exp.delete();
        fss_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sspfssout) fss_seen++;
        end
        check("rst_tx_fifo_flushed", fss_seen, 0);
        check("rst_rx_fifo_flushed", prdata, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssp_serial_port.md
Name: ssp_serial_port

Overview:
- Synchronous serial port (TI-style frame format) with an APB-like 8-bit parallel interface.
- Parallel words written by the host go through a 4-deep TX FIFO and are shifted out MSB-first with a frame pulse and output clock.
- Serial words received on ssprxd are assembled into bytes and pushed into a 4-deep RX FIFO for the host to read.
- Interrupt outputs flag a full TX FIFO and a full RX FIFO.

Parameters:
- none. Word width is fixed at 8; FIFO depth is fixed at 4.

Ports:
- pclk  in  1  sole clock; all logic on its rising edge
- clear_b  in  1  reset, synchronous, active-high (the name is kept despite the _b suffix)
- psel  in  1  bus select
- pwrite  in  1  1 = write to TX FIFO, 0 = read from RX FIFO (valid when psel=1)
- pwdata  in  8  write data
- prdata  out  8  RX FIFO head
- sspclkin  in  1  receive serial clock, sampled as data in the pclk domain
- sspfssin  in  1  receive frame pulse
- ssprxd  in  1  receive serial data
- ssptxd  out  1  transmit serial data
- sspclkout  out  1  transmit serial clock, pclk/2
- sspfssout  out  1  transmit frame pulse
- sspoe_b  out  1  active-low output enable for ssptxd
- ssptxintr  out  1  TX FIFO full
- ssprxintr  out  1  RX FIFO full

Behaviour:
- Reset (clear_b=1 at a pclk edge):
  - Both FIFOs empty; all state machines idle.
  - Outputs: sspclkout=0, sspfssout=0, ssptxd=0, sspoe_b=1, ssptxintr=0, ssprxintr=0, prdata=0.
  - Reset mid-frame aborts the frame immediately.
- Host write (psel=1, pwrite=1):
  - pwdata is pushed to the TX FIFO on that edge.
  - Accepted if count<4, or if a TX pop occurs on the same edge.
  - Otherwise the write is silently dropped.
- Host read (psel=1, pwrite=0):
  - prdata combinationally shows the RX FIFO head (0 when empty).
  - A read pops the head at the edge; a read when empty has no effect.
  - An RX push and a pop on the same edge are both honoured.
- Interrupts:
  - ssptxintr = (TX count==4).
  - ssprxintr = (RX count==4).
  - Both are registered with the counts and update the cycle after the causing edge.
- Serial clock: sspclkout toggles every pclk edge after reset (period 2 pclk). A "serial tick" is a pclk edge where sspclkout goes 0->1; all TX outputs change only on serial ticks.
- TX FSM, states IDLE, FRAME, SHIFT; bit counter 7..0:
  - IDLE: at a tick with the TX FIFO non-empty, pop the head into the shift register, set sspfssout=1 -> FRAME.
  - FRAME: at the next tick, sspfssout=0, sspoe_b=0, ssptxd=bit7, counter=7 -> SHIFT.
  - SHIFT: each tick outputs the next lower bit.
  - When bit0 is driven and the FIFO is non-empty: pop the next word and drive sspfssout=1 during the bit0 period (back-to-back, no idle gap). At the next tick, bit7 of the new word is driven with sspfssout=0.
  - When bit0 is driven and the FIFO is empty: at the next tick, sspoe_b=1, ssptxd=0 -> IDLE.
- RX path:
  - sspclkin, sspfssin and ssprxd are registered once per pclk.
  - A falling edge is detected when the previous sample is 1 and the current sample is 0.
  - On a falling edge with sspfssin=1 and the receiver idle (or on its 8th bit): arm for a new word.
  - Each of the following 8 falling edges shifts in ssprxd, MSB first.
  - After the 8th bit the byte is pushed to the RX FIFO; it is dropped if the FIFO is full and no pop occurs that cycle.
- Latency: a write on edge N is in the FIFO after N; the frame pulse starts at the first tick after N (within 2 pclk).

Test Plan:
- Reset held, psel=1, pwdata=FF -> FIFOs empty, sspoe_b=1, sspclkout=0, no write accepted.
- Release reset, write 0F, AA, F0, 55, 0F, FF on consecutive pclks -> 0F popped by the first tick; the FIFO fills with AA, F0, 55, 0F; ssptxintr=1; FF is dropped.
- Continue the previous scenario -> ssptxd emits 0F, AA, F0, 55, 0F MSB-first.
  - Single sspfssout pulse before each word, overlapping the previous bit0 for back-to-back words.
  - sspoe_b low continuously across all words, then returns high; ssptxintr clears after the first pop.
- Loop ssptxd->ssprxd, sspclkout->sspclkin, sspfssout->sspfssin, write A5 -> RX FIFO receives A5; a read with psel=1, pwrite=0 gives prdata=A5, then 0.
- Receive 5 words without reading -> ssprxintr=1 after the 4th; the 5th is dropped; 4 reads return the first 4 in order.
- Assert clear_b mid-word -> next edge: sspoe_b=1, FIFOs empty, both interrupts 0.
